multi_timer: RTL and testbench

Parametrised multi-channel bus timer: the successor to the single-channel timer peripheral on the 8-bit CPU data bus. It provides NUM_CH independent channels, each with an 8-bit period, a periodic or one-shot mode and its own interrupt line. All channels count ticks from one shared prescaler. Each interrupt line plugs into the CPU's BUS_INTERRUPTS_RAISE/ACK vectors.

---
 rtl/multi_timer.sv | 172 +++++++++++++++++
 tb/tb_multi_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// multi_timer: multi-channel bus timer on the 8-bit CPU data bus.
//
// Each channel has an 8-bit period, a periodic or one-shot mode and its own
// level interrupt line. All channels advance on one shared prescaler tick.
//
// Ports
//   i_clk                  system clock, all state on the rising edge
//   i_rst_n                asynchronous active-low reset
//   i_bus_addr[7:0]        bus address
//   io_bus_data[7:0]       bus data; driven only while returning read data
//   i_bus_we               bus write enable
//   o_bus_interrupt_raise  per-channel interrupt request (PEND, registered)
//   i_bus_interrupt_ack    per-channel acknowledge, level-sampled
//
// Register window: channel c at BASE_ADDR+4c .. BASE_ADDR+4c+3
//   +0 CTRL   {4'b0, PEND(ro), IRQ_EN, MODE, EN}
//   +1 PERIOD
//   +2 COUNT  (any write clears it)
//   +3 STATUS {7'b0, PEND} (any write clears PEND)
module multi_timer #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         NUM_CH    = 2,
  parameter int         PRESCALE  = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_bus_addr,
  inout  wire  [7:0]        io_bus_data,
  input  logic              i_bus_we,
  output logic [NUM_CH-1:0] o_bus_interrupt_raise,
  input  logic [NUM_CH-1:0] i_bus_interrupt_ack
);

  localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic          w_tick;

  logic          w_in_win;
  logic [1:0]    w_ch_idx;
  logic [1:0]    w_off;
  logic          w_wr;
  logic          w_rd;
  logic [7:0]    w_wdata;

  logic [7:0]    w_ch_rd [NUM_CH];
  logic [7:0]    w_rd_data;
  logic [7:0]    r_rd_data;
  logic          r_rd_vld;

  // Shared prescaler, free-running 0..PRESCALE-1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == PRESC_MAX);

  // The window is 16-aligned, so the upper nibble alone selects it
  assign w_in_win = (i_bus_addr[7:4] == BASE_ADDR[7:4]);
  assign w_ch_idx = i_bus_addr[3:2];
  assign w_off    = i_bus_addr[1:0];
  assign w_wr     = w_in_win & i_bus_we;
  assign w_rd     = w_in_win & ~i_bus_we;
  assign w_wdata  = io_bus_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic       r_en;
    logic       r_mode;
    logic       r_irq_en;
    logic       r_pend;
    logic [7:0] r_period;
    logic [7:0] r_count;

    logic       w_sel;
    logic       w_wr_ctrl;
    logic       w_wr_period;
    logic       w_wr_count;
    logic       w_wr_status;
    logic       w_expire;
    logic       w_en_rise;

    assign w_sel       = w_wr && (w_ch_idx == 2'(c));
    assign w_wr_ctrl   = w_sel && (w_off == 2'd0);
    assign w_wr_period = w_sel && (w_off == 2'd1);
    assign w_wr_count  = w_sel && (w_off == 2'd2);
    assign w_wr_status = w_sel && (w_off == 2'd3);

    // >= rather than == so a period lowered below the count still expires
    assign w_expire  = w_tick && r_en && (r_count >= r_period);
    assign w_en_rise = w_wr_ctrl && w_wdata[0] && !r_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_en     <= 1'b0;
        r_mode   <= 1'b0;
        r_irq_en <= 1'b0;
        r_pend   <= 1'b0;
        r_period <= 8'd0;
        r_count  <= 8'd0;
      end else begin
        // One-shot expiry wins over a CTRL write re-enabling the channel
        if (w_expire && r_mode) begin
          r_en <= 1'b0;
        end else if (w_wr_ctrl) begin
          r_en <= w_wdata[0];
        end

        if (w_wr_ctrl) begin
          r_mode   <= w_wdata[1];
          r_irq_en <= w_wdata[2];
        end

        if (w_wr_period) begin
          r_period <= w_wdata;
        end

        // Bus clears take priority over the tick update
        if (w_wr_count || w_en_rise) begin
          r_count <= 8'd0;
        end else if (w_tick && r_en) begin
          r_count <= w_expire ? 8'd0 : r_count + 8'd1;
        end

        // A new expiry wins over ACK / STATUS clear in the same cycle
        if (w_expire && r_irq_en) begin
          r_pend <= 1'b1;
        end else if (i_bus_interrupt_ack[c] || w_wr_status) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign o_bus_interrupt_raise[c] = r_pend;

    assign w_ch_rd[c] = (w_off == 2'd0) ? {4'b0000, r_pend, r_irq_en, r_mode, r_en} :
                        (w_off == 2'd1) ? r_period :
                        (w_off == 2'd2) ? r_count :
                                          {7'b0000000, r_pend};
  end

  // Channels beyond NUM_CH inside the window read as 0
  always_comb begin
    w_rd_data = 8'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_idx == 2'(c)) begin
        w_rd_data = w_ch_rd[c];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= 8'd0;
    end else begin
      r_rd_vld <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_rd_data;
      end
    end
  end

  assign io_bus_data = r_rd_vld ? r_rd_data : 8'bzzzzzzzz;

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

  localparam logic [7:0] IDLE = 8'h00;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic       we;
  logic [1:0] ack;
  wire  [1:0] raise;
  logic       drv;
  logic [7:0] drv_dat;
  wire  [7:0] bus_data;
  wire        bus_is_z;

  int         cyc;
  int         n_tests;
  int         n_fail;
  logic [7:0] exp_q[$];

  assign bus_data = drv ? drv_dat : 8'bzzzzzzzz;
  assign bus_is_z = (bus_data === 8'bzzzzzzzz);

  multi_timer #(
    .BASE_ADDR(8'hF0),
    .NUM_CH   (2),
    .PRESCALE (4)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_bus_addr           (addr),
    .io_bus_data          (bus_data),
    .i_bus_we             (we),
    .o_bus_interrupt_raise(raise),
    .i_bus_interrupt_ack  (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; with PRESCALE=4 tick edges are cyc%4==0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Count after edge e for a channel with PERIOD=3 whose count was 0 at edge refc
  function automatic logic [7:0] cnt_exp(input int e, input int refc);
    return 8'((e / 4 - refc / 4) % 4);
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; drv = 1'b1; drv_dat = d;
    @(negedge clk);
    we = 1'b0; addr = IDLE; drv = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] e);
    we = 1'b0; addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    addr = IDLE;
    check(tag, {24'd0, bus_data}, {24'd0, exp_q.pop_front()});
    @(negedge clk);
    check({tag, "_release"}, bus_is_z, 1);
  endtask

  task automatic burst(input string tag, input logic [7:0] a, input int n, input int refc);
    we = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) check(tag, {24'd0, bus_data}, {24'd0, exp_q.pop_front()});
      if (i < n) begin
        addr = a;
        exp_q.push_back(cnt_exp(cyc, refc));
      end else begin
        addr = IDLE;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_raise(input int ch, input int budget, output int t);
    logic found;
    found = 1'b0;
    t = -1;
    for (int k = 0; k < budget && !found; k++) begin
      if (raise[ch]) begin
        found = 1'b1;
        t = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check("raise_seen", found, 1);
  endtask

  task automatic ack_pulse(input int ch);
    ack[ch] = 1'b1;
    @(negedge clk);
    ack[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, r, r1, r2, r3, seen;
    we = 1'b0; addr = IDLE; drv = 1'b0; drv_dat = 8'd0; ack = 2'b00;
    rst_n = 1'b0; n_tests = 0; n_fail = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_raise", raise, 0);
    check("rst_bus_z", bus_is_z, 1);
    rst_n = 1'b1;
    @(negedge clk);
    rd("rst_ctrl0",   8'hF0, 8'h00);
    rd("rst_period0", 8'hF1, 8'h00);
    rd("rst_count0",  8'hF2, 8'h00);
    rd("rst_status0", 8'hF3, 8'h00);

    // Periodic channel 0, PERIOD=3 -> raise every 16 clocks
    wr(8'hF1, 8'd3);
    wr(8'hF0, 8'h05);
    w = cyc;
    wait_raise(0, 100, r1);
    check("per_first_ticks", r1 / 4 - w / 4, 4);
    check("per_tick_align", r1 % 4, 0);
    ack_pulse(0);
    check("per_ack_low", raise[0], 0);
    wait_raise(0, 100, r2);
    check("per_interval1", r2 - r1, 16);
    ack_pulse(0);
    check("per_ack_low2", raise[0], 0);
    wait_raise(0, 100, r3);
    check("per_interval2", r3 - r2, 16);
    ack_pulse(0);
    burst("per_count", 8'hF2, 16, r3);
    wr(8'hF0, 8'h00);
    ack[0] = 1'b1;
    repeat (2) @(negedge clk);
    ack[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("per_stopped", raise, 0);

    // One-shot channel 1, PERIOD=2 -> single raise after 3 ticks
    wr(8'hF5, 8'd2);
    wr(8'hF4, 8'h07);
    w = cyc;
    wait_raise(1, 100, r);
    check("os_ticks", r / 4 - w / 4, 3);
    rd("os_ctrl", 8'hF4, 8'h0E);
    ack_pulse(1);
    check("os_ack_low", raise[1], 0);
    seen = 0;
    repeat (84) begin
      @(negedge clk);
      if (raise[1]) seen++;
    end
    check("os_no_rearm", seen, 0);
    rd("os_ctrl_after", 8'hF4, 8'h06);

    // Set/clear collision: PERIOD=0 with ACK held high
    wr(8'hF1, 8'd0);
    ack[0] = 1'b1;
    wr(8'hF0, 8'h05);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      check("col_raise", raise[0], (cyc % 4 == 0));
      @(negedge clk);
    end
    wr(8'hF0, 8'h00);
    repeat (2) @(negedge clk);
    ack[0] = 1'b0;
    @(negedge clk);
    check("col_off", raise, 0);

    // Bus isolation
    addr = 8'hEF; we = 1'b0;
    @(negedge clk);
    addr = IDLE;
    check("iso_out_z1", bus_is_z, 1);
    @(negedge clk);
    check("iso_out_z2", bus_is_z, 1);
    wr(8'hF5, 8'h55);
    rd("iso_period0", 8'hF1, 8'h00);
    check("iso_pre_z", bus_is_z, 1);
    rd("iso_period1", 8'hF5, 8'h55);
    wr(8'hF9, 8'h12);
    rd("iso_unused", 8'hF9, 8'h00);

    // IRQ masking: counts and wraps, PEND stays 0
    wr(8'hF1, 8'd3);
    wr(8'hF0, 8'h01);
    w = cyc;
    repeat (8) @(negedge clk);
    burst("mask_count", 8'hF2, 20, w);
    check("mask_raise", raise[0], 0);
    rd("mask_status", 8'hF3, 8'h00);

    // IRQ enabled, then STATUS write clears
    wr(8'hF0, 8'h05);
    wait_raise(0, 100, r);
    wr(8'hF3, 8'hFF);
    check("stat_clr", raise[0], 0);

    // Reset mid-operation with PEND=1 and a read in flight
    wait_raise(0, 100, r);
    addr = 8'hF2; we = 1'b0;
    @(negedge clk);
    addr = IDLE;
    rst_n = 1'b0;
    #1;
    check("mid_rst_raise", raise, 0);
    check("mid_rst_z", bus_is_z, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("mid_ctrl0",   8'hF0, 8'h00);
    rd("mid_period0", 8'hF1, 8'h00);
    rd("mid_count0",  8'hF2, 8'h00);
    rd("mid_status0", 8'hF3, 8'h00);
    rd("mid_period1", 8'hF5, 8'h00);
    check("mid_raise_after", raise, 0);
    wr(8'hF0, 8'h05);
    wait_raise(0, 20, r);
    check("mid_presc_align", r % 4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
